// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults, derived totals and sync polarity encoding
// for the VGA raster timing generator.
package vga_timing_pkg;

  localparam int COUNT_W = 10;
  localparam int MAX_TOTAL = 1 << COUNT_W;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Sync windows are half-open: [START, END)
  localparam int H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
  localparam int V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  localparam sync_pol_e DEF_SYNC_POL = SYNC_ACTIVE_LOW;

  function automatic logic sync_level(input sync_pol_e pol, input logic active);
    return active ? logic'(pol) : ~logic'(pol);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap flag plus registered sync and
// visible-region flags that describe the same position as count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
  output logic [COUNT_W-1:0] count,
  output logic               wrap,
  output logic               sync_active,
  output logic               active
);

  localparam int TOTAL      = VISIBLE + FRONT + SYNC + BACK;
  localparam int SYNC_START = VISIBLE + FRONT;
  localparam int SYNC_END   = SYNC_START + SYNC;

  generate
    if (TOTAL >= MAX_TOTAL) begin : g_total_too_large
      $error("vga_axis_counter: total %0d does not fit a %0d-bit counter", TOTAL, COUNT_W);
    end
  endgenerate

  localparam logic [COUNT_W-1:0] LAST_V       = COUNT_W'(TOTAL - 1);
  localparam logic [COUNT_W-1:0] VISIBLE_V    = COUNT_W'(VISIBLE);
  localparam logic [COUNT_W-1:0] SYNC_START_V = COUNT_W'(SYNC_START);
  localparam logic [COUNT_W-1:0] SYNC_END_V   = COUNT_W'(SYNC_END);

  // Flag values for position 0, used at reset
  localparam logic RST_SYNC   = (SYNC_START == 0) && (SYNC_END > 0);
  localparam logic RST_ACTIVE = (VISIBLE > 0);

  logic [COUNT_W-1:0] count_next;

  assign wrap = (count == LAST_V);

  always_comb begin
    count_next = count;
    if (step) begin
      count_next = wrap ? '0 : count + 1'b1;
    end
  end

  // Flags are derived from count_next so they land in the same cycle as count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count       <= '0;
      sync_active <= RST_SYNC;
      active      <= RST_ACTIVE;
    end else begin
      count       <= count_next;
      sync_active <= (count_next >= SYNC_START_V) && (count_next < SYNC_END_V);
      active      <= (count_next < VISIBLE_V);
    end
  end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: horizontal/vertical counters, polarity-adjusted
// syncs, display enable, line/frame ticks and a wrapping frame counter.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int        H_VISIBLE = DEF_H_VISIBLE,
  parameter int        H_FRONT   = DEF_H_FRONT,
  parameter int        H_SYNC    = DEF_H_SYNC,
  parameter int        H_BACK    = DEF_H_BACK,
  parameter int        V_VISIBLE = DEF_V_VISIBLE,
  parameter int        V_FRONT   = DEF_V_FRONT,
  parameter int        V_SYNC    = DEF_V_SYNC,
  parameter int        V_BACK    = DEF_V_BACK,
  parameter sync_pol_e SYNC_POL  = DEF_SYNC_POL
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic [9:0] x_px,
  output logic [9:0] y_px,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_tick,
  output logic       frame_tick,
  output logic [7:0] frame_count
);

  logic h_wrap;
  logic h_sync_active;
  logic h_active;
  logic v_step;
  logic v_wrap;
  logic v_sync_active;
  logic v_active;

  // The vertical axis advances only on an enabled last pixel of the line
  assign v_step = h_wrap & pix_en;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK)
  ) u_h_axis (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (pix_en),
    .count      (x_px),
    .wrap       (h_wrap),
    .sync_active(h_sync_active),
    .active     (h_active)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK)
  ) u_v_axis (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (v_step),
    .count      (y_px),
    .wrap       (v_wrap),
    .sync_active(v_sync_active),
    .active     (v_active)
  );

  assign hsync      = sync_level(SYNC_POL, h_sync_active);
  assign vsync      = sync_level(SYNC_POL, v_sync_active);
  assign display_on = h_active & v_active;
  assign line_tick  = h_wrap & pix_en;
  assign frame_tick = line_tick & v_wrap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_count <= '0;
    end else if (frame_tick) begin
      frame_count <= frame_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default 640x480 instance plus a shrunken-geometry
// instance for frame-level cases, both checked against an arithmetic raster model.
module tb_vga_timing;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       de;
    logic       lt;
    logic       ft;
    logic [7:0] fc;
  } obs_t;

  typedef struct {
    logic en;
    int   x;
    logic lt;
  } vec_t;

  typedef struct {
    int   x;
    int   y;
    logic de;
  } de_pt_t;

  // Small geometry: 16 pixels x 11 lines = 176 cycles per frame
  localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 3;
  localparam int S_VV = 6, S_VF = 1, S_VS = 2, S_VB = 2;
  localparam int S_FRAME = 176;

  logic clk = 1'b0;
  logic rst_n;
  logic pix_en;

  logic [9:0] x_d, y_d, x_s, y_s;
  logic hs_d, vs_d, de_d, lt_d, ft_d, hs_s, vs_s, de_s, lt_s, ft_s;
  logic [7:0] fc_d, fc_s;

  int n_checks = 0;
  int n_fail = 0;
  longint n = 0;
  logic armed = 1'b0;
  obs_t od, os, ed, es;

  always #5 clk = ~clk;

  vga_timing u_dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .x_px(x_d), .y_px(y_d), .hsync(hs_d), .vsync(vs_d), .display_on(de_d),
    .line_tick(lt_d), .frame_tick(ft_d), .frame_count(fc_d)
  );

  vga_timing #(
    .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
  ) u_dut_small (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .x_px(x_s), .y_px(y_s), .hsync(hs_s), .vsync(vs_s), .display_on(de_s),
    .line_tick(lt_s), .frame_tick(ft_s), .frame_count(fc_s)
  );

  // Raster position from the number of enabled cycles since reset
  function automatic obs_t model(input int hv, input int hf, input int hsw, input int hb,
                                 input int vv, input int vf, input int vsw, input int vb,
                                 input longint cnt, input logic en);
    obs_t o;
    int ht, vtot, x, y;
    longint pix, frames;
    ht = hv + hf + hsw + hb;
    vtot = vv + vf + vsw + vb;
    pix = cnt % (ht * vtot);
    frames = cnt / (ht * vtot);
    x = int'(pix % ht);
    y = int'(pix / ht);
    o.x = 10'(x);
    o.y = 10'(y);
    o.hs = !((x >= hv + hf) && (x < hv + hf + hsw));
    o.vs = !((y >= vv + vf) && (y < vv + vf + vsw));
    o.de = (x < hv) && (y < vv);
    o.lt = en && (x == ht - 1);
    o.ft = o.lt && (y == vtot - 1);
    o.fc = 8'(frames % 256);
    return o;
  endfunction

  task automatic cmp_obs(input string nm, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s n=%0d actual x=%0d y=%0d hs=%b vs=%b de=%b lt=%b ft=%b fc=%0d required x=%0d y=%0d hs=%b vs=%b de=%b lt=%b ft=%b fc=%0d",
               nm, n, act.x, act.y, act.hs, act.vs, act.de, act.lt, act.ft, act.fc,
               exp.x, exp.y, exp.hs, exp.vs, exp.de, exp.lt, exp.ft, exp.fc);
    end
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample outputs, then let the edge happen
  task automatic cyc(input logic en, input logic rn);
    @(negedge clk);
    pix_en = en;
    rst_n = rn;
    #1;
    od = {x_d, y_d, hs_d, vs_d, de_d, lt_d, ft_d, fc_d};
    os = {x_s, y_s, hs_s, vs_s, de_s, lt_s, ft_s, fc_s};
    if (armed) begin
      ed = model(640, 16, 96, 48, 480, 10, 2, 33, n, en);
      es = model(S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, n, en);
      cmp_obs("model_default", od, ed);
      cmp_obs("model_small", os, es);
    end
    @(posedge clk);
    if (!rn) begin
      n = 0;
      armed = 1'b1;
    end else if (en) begin
      n++;
    end
  endtask

  initial begin
    vec_t   tick_vec[7];
    de_pt_t de_pts[5];
    int hs_low, hs_first, hs_last, lt_cnt, lt_x, bad, found;
    int vs_low, ft_cnt, ft_x, ft_y, y0_again;
    logic left_zero;

    tick_vec[0] = '{1'b1, 797, 1'b0};
    tick_vec[1] = '{1'b1, 798, 1'b0};
    tick_vec[2] = '{1'b0, 799, 1'b0};
    tick_vec[3] = '{1'b1, 799, 1'b1};
    tick_vec[4] = '{1'b0, 0,   1'b0};
    tick_vec[5] = '{1'b1, 0,   1'b0};
    tick_vec[6] = '{1'b0, 1,   1'b0};

    de_pts[0] = '{0, 0, 1'b1};
    de_pts[1] = '{S_HV - 1, S_VV - 1, 1'b1};
    de_pts[2] = '{S_HV, 0, 1'b0};
    de_pts[3] = '{0, S_VV, 1'b0};
    de_pts[4] = '{15, 10, 1'b0};

    pix_en = 1'b0;
    rst_n = 1'b0;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);

    // One full line on the default geometry
    hs_low = 0; hs_first = -1; hs_last = -1; lt_cnt = 0; lt_x = -1;
    for (int k = 0; k < 800; k++) begin
      cyc(1'b1, 1'b1);
      if (k == 0) begin
        chk("rst_x", od.x, 0);
        chk("rst_y", od.y, 0);
        chk("rst_de", od.de, 1);
        chk("rst_hsync", od.hs, 1);
        chk("rst_vsync", od.vs, 1);
        chk("rst_fc", od.fc, 0);
        chk("rst_lt", od.lt, 0);
      end
      if (!od.hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = od.x;
        hs_last = od.x;
      end
      if (od.lt) begin
        lt_cnt++;
        lt_x = od.x;
      end
      if (k == 799) chk("y_before_wrap", od.y, 0);
    end
    cyc(1'b1, 1'b1);
    chk("x_wrap", od.x, 0);
    chk("y_after_wrap", od.y, 1);
    chk("hsync_low_cycles", hs_low, 96);
    chk("hsync_first_x", hs_first, 656);
    chk("hsync_last_x", hs_last, 751);
    chk("line_tick_count", lt_cnt, 1);
    chk("line_tick_x", lt_x, 799);

    // Freeze at x=300 for 50 disabled cycles
    found = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc(1'b1, 1'b1);
      if (od.x == 10'd299) begin found = 1; break; end
    end
    chk("reach_x300", found, 1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1'b0, 1'b1);
      if (od.x != 10'd300 || od.y != 10'd1 || od.lt || od.ft || !od.hs || !od.de) bad++;
    end
    chk("freeze_bad_cycles", bad, 0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    chk("resume_x", od.x, 301);

    // pix_en toggling across the last pixel of the line
    found = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc(1'b1, 1'b1);
      if (od.x == 10'd796) begin found = 1; break; end
    end
    chk("reach_x796", found, 1);
    for (int i = 0; i < 7; i++) begin
      cyc(tick_vec[i].en, 1'b1);
      chk($sformatf("toggle_x[%0d]", i), od.x, tick_vec[i].x);
      chk($sformatf("toggle_lt[%0d]", i), od.lt, tick_vec[i].lt);
    end

    // Full frame on the small geometry
    cyc(1'b1, 1'b0);
    vs_low = 0; ft_cnt = 0; ft_x = -1; ft_y = -1; y0_again = -1; left_zero = 1'b0;
    for (int k = 0; k <= S_FRAME; k++) begin
      cyc(1'b1, 1'b1);
      if (k == 0) begin
        chk("small_rst_fc", os.fc, 0);
        chk("small_rst_vsync", os.vs, 1);
      end
      if (!os.vs) vs_low++;
      if (os.ft) begin
        ft_cnt++;
        ft_x = os.x;
        ft_y = os.y;
      end
      if (os.y != 10'd0) left_zero = 1'b1;
      else if (left_zero && y0_again < 0) y0_again = k;
      foreach (de_pts[p]) begin
        if (os.x == 10'(de_pts[p].x) && os.y == 10'(de_pts[p].y))
          chk($sformatf("display_on(%0d,%0d)", de_pts[p].x, de_pts[p].y), os.de, de_pts[p].de);
      end
    end
    chk("vsync_low_cycles", vs_low, 2 * 16);
    chk("frame_tick_count", ft_cnt, 1);
    chk("frame_tick_x", ft_x, 15);
    chk("frame_tick_y", ft_y, 10);
    chk("y0_again_cycle", y0_again, S_FRAME);
    chk("fc_after_frame", os.fc, 1);

    // Mid-frame reset with both syncs active
    found = 0;
    for (int i = 0; i < 400; i++) begin
      cyc(1'b1, 1'b1);
      if (os.x == 10'd10 && os.y == 10'd8) begin found = 1; break; end
    end
    chk("reach_sync_point", found, 1);
    cyc(1'b1, 1'b0);
    chk("pre_rst_hsync", os.hs, 0);
    chk("pre_rst_vsync", os.vs, 0);
    cyc(1'b1, 1'b1);
    chk("post_rst_x", os.x, 0);
    chk("post_rst_y", os.y, 0);
    chk("post_rst_hsync", os.hs, 1);
    chk("post_rst_vsync", os.vs, 1);
    chk("post_rst_de", os.de, 1);
    chk("post_rst_fc", os.fc, 0);

    // 256 frames: frame_count wraps 255 -> 0
    for (int k = 1; k <= 256 * S_FRAME; k++) begin
      cyc(1'b1, 1'b1);
      if (k == 256 * S_FRAME - 1) begin
        chk("fc_before_wrap", os.fc, 255);
        chk("ft_before_wrap", os.ft, 1);
      end
      if (k == 256 * S_FRAME) begin
        chk("fc_wrapped", os.fc, 0);
        chk("xy_wrapped", {os.x, os.y}, 0);
      end
    end

    // Random enables with occasional resets, checked by the model
    for (int i = 0; i < 4000; i++) begin
      cyc(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 499) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
Generates 640x480@60 VGA raster timing from a 25 MHz-class pixel clock. It is the stage directly upstream of the snake game renderer: it supplies the x_px/y_px pixel coordinates that the renderer decodes into colour, and it supplies hsync/vsync/display_on to the top-level output stage. x_px/y_px are raw counters that also run through blanking, so display_on must be used downstream to blank colour.

Parameters:
H_VISIBLE  640  active pixels per line
H_FRONT    16   horizontal front porch, pixels
H_SYNC     96   hsync pulse width, pixels
H_BACK     48   horizontal back porch, pixels
V_VISIBLE  480  active lines per frame
V_FRONT    10   vertical front porch, lines
V_SYNC     2    vsync pulse width, lines
V_BACK     33   vertical back porch, lines
SYNC_POL   0    sync active level (0 = active-low, the 640x480 standard)

Ports:
clk         in   1   pixel clock
rst_n       in   1   reset
pix_en      in   1   pixel clock enable; counters advance only when high
x_px        out  10  horizontal counter, 0..H_TOTAL-1
y_px        out  10  vertical counter, 0..V_TOTAL-1
hsync       out  1   horizontal sync at SYNC_POL level
vsync       out  1   vertical sync at SYNC_POL level
display_on  out  1   high when x_px<H_VISIBLE and y_px<V_VISIBLE
line_tick   out  1   1-cycle pulse on the last pixel of each line
frame_tick  out  1   1-cycle pulse on the last pixel of each frame
frame_count out  8   frames completed since reset, wraps at 256

Behaviour:
- Reset: rst_n is synchronous and active-low; clock is clk. Reset takes precedence over pix_en. It may be asserted mid-line or mid-frame.
- Reset values: x_px=0, y_px=0, display_on=1, hsync=vsync=!SYNC_POL, frame_count=0, line_tick=frame_tick=0.
- Derived totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Advance rule: on a clk edge with pix_en=1, x_px increments. When x_px==H_TOTAL-1, x_px wraps to 0 and y_px increments. When y_px==V_TOTAL-1 at that same edge, y_px also wraps to 0 and frame_count increments modulo 256.
- Hold rule: with pix_en=0, all registered state holds.
- Alignment: hsync, vsync and display_on are registered outputs. They are computed from the next-state counter values, so each one describes the same pixel as the current x_px/y_px. There is zero relative latency and no combinational path from the counters to the outputs.
- hsync window: active for H_VISIBLE+H_FRONT <= x_px < H_VISIBLE+H_FRONT+H_SYNC, which is 656..751.
- vsync window: active for V_VISIBLE+V_FRONT <= y_px < V_VISIBLE+V_FRONT+V_SYNC, which is lines 490..491. vsync changes together with y_px, at the x wrap.
- line_tick = (x_px==H_TOTAL-1) AND pix_en.
- frame_tick = line_tick AND (y_px==V_TOTAL-1).
- Tick pulses: line_tick and frame_tick are therefore exactly one enabled cycle long, even if pix_en toggles.
- y_px stability: y_px changes only at the x wrap, so it is stable for a whole line. The renderer's "y_px changed and equals 0" detection therefore fires exactly once per frame.
- Counter widths: 10 bits are sufficient for the defaults. Parameter sets with a total of 1024 or more are unsupported; elaboration must stop with an error.

Decomposition:
- Package vga_timing_pkg holds:
  - default 640x480 timing constants and derived H_TOTAL/V_TOTAL;
  - sync-start and sync-end constants;
  - the SYNC_POL encoding.
- Sub-module vga_axis_counter, instantiated twice (horizontal and vertical):
  - parameters VISIBLE, FRONT, SYNC, BACK;
  - inputs: clk, rst_n, step;
  - outputs: count, wrap (combinational last-value flag), sync_active, active.
  - The vertical instance's step is the horizontal instance's wrap AND pix_en.
- Top level adds polarity, the tick outputs and frame_count.

Test Plan:
1. Reset with pix_en=1, then 800 cycles:
   - x_px runs 0..799 and returns to 0; y_px goes 0->1 on the cycle x_px wraps.
   - hsync is low exactly for x_px 656..751 (96 cycles).
   - line_tick is high only while x_px=799.
2. Run a full 420000 cycles:
   - vsync is low for exactly y_px 490..491 (1600 cycles).
   - frame_tick pulses once, at x_px=799, y_px=524.
   - frame_count goes 0->1; y_px==0 is first seen again at cycle 420000.
3. display_on check:
   - high at (0,0), (639,479);
   - low at (640,0), (0,480), (799,524).
   - Sampled against x_px/y_px in the same cycle.
4. pix_en held 0 for 50 cycles mid-line at x_px=300: all outputs frozen at their x_px=300 values, no ticks. Then pix_en=1: x_px resumes at 301.
5. pix_en toggling 1,0,1,0 across x_px=799: line_tick is high only in the single pix_en=1 cycle at x_px=799.
6. rst_n low for one cycle at x_px=700, y_px=491 (hsync and vsync both active):
   - next cycle: x_px=0, y_px=0, both syncs inactive, display_on=1, frame_count=0.
   - After 256 full frames, frame_count wraps 255->0.
